// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset defaults and the PC update rule.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EXEC  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;
  localparam int          WAIT_MAX_DEFAULT     = 8;

  // PC after an instruction retires: sequential step (wrapping) or page/offset jump.
  function automatic logic [15:0] next_pc(
    input logic [15:0] pc,
    input logic        jump,
    input logic        page,
    input logic        page0,
    input logic [7:0]  imm,
    input logic [7:0]  acc
  );
    logic [7:0] hi;
    logic [7:0] lo;
    lo = page0 ? imm : acc;
    hi = page ? acc : pc[15:8];
    return jump ? {hi, lo} : (pc + 16'd1);
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch sequencer: fetches PRG from the
// program ROM with a timeout retry, then holds it until the datapath retires it.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          WAIT_MAX     = WAIT_MAX_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        ROM_REQ,
  output logic [15:0] ROM_ADDR,
  input  logic        ROM_ACK,
  input  logic [15:0] ROM_DATA,
  output logic [15:0] PRG,
  output logic        PRG_VALID,
  input  logic        EXEC_DONE,
  input  logic        JUMP,
  input  logic        PAGE,
  input  logic        PAGE0,
  input  logic [7:0]  IMM,
  input  logic [7:0]  ACC,
  output logic [15:0] PC,
  output logic        FETCH_ERR
);

  localparam int               CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  fetch_state_e     state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      prg_q, prg_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rom_req_q, rom_req_d;
  logic             prg_valid_q, prg_valid_d;

  // Next-state logic: fetch handshake, WAIT timeout retry and PC update on retire.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    prg_d   = prg_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ROM_ACK) begin
          prg_d   = ROM_DATA;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          // ROM never answered: flag it and re-request the same address.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (EXEC_DONE) begin
          pc_d    = next_pc(pc_q, JUMP, PAGE, PAGE0, IMM, ACC);
          state_d = ST_FETCH;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight from flops.
    rom_req_d   = (state_d == ST_FETCH);
    prg_valid_d = (state_d == ST_EXEC);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (RST) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      prg_q       <= 16'h0000;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rom_req_q   <= 1'b0;
      prg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      prg_q       <= prg_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rom_req_q   <= rom_req_d;
      prg_valid_q <= prg_valid_d;
    end
  end

  assign ROM_REQ   = rom_req_q;
  assign ROM_ADDR  = pc_q;
  assign PC        = pc_q;
  assign PRG       = prg_q;
  assign PRG_VALID = prg_valid_q;
  assign FETCH_ERR = err_q;

endmodule
